// File: rtl/jk_mod_counter_pkg.sv
// Shared constants, next-state selector encoding and the JK excitation helper
// for the modulo-N counter built from JK stages.
package jk_mod_counter_pkg;

  localparam logic DIR_UP          = 1'b1;
  localparam logic DIR_DOWN        = 1'b0;
  localparam int   DEFAULT_WIDTH   = 4;
  localparam int   DEFAULT_MODULUS = 10;

  typedef enum logic [1:0] {
    NS_HOLD = 2'd0,
    NS_LOAD = 2'd1,
    NS_INC  = 2'd2,
    NS_DEC  = 2'd3
  } ns_sel_e;

  // Returns {J, K} that moves a stage from q to nxt; never produces J=K=1.
  function automatic logic [1:0] jk_excite(input logic nxt, input logic q);
    return {nxt & ~q, ~nxt & q};
  endfunction

endpackage

// File: rtl/jk_mod_counter_jk_stage.sv
// Single JK flip-flop storage stage: hold, reset, set, toggle; async active-low clear.
module jk_stage (
  input  logic clk2,
  input  logic a_reset,
  input  logic J,
  input  logic K,
  output logic Q
);

  logic r_q;

  // JK state register
  always_ff @(posedge clk2 or negedge a_reset) begin
    if (!a_reset) begin
      r_q <= 1'b0;
    end else begin
      case ({J, K})
        2'b00:   r_q <= r_q;
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        2'b11:   r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter: synchronized, edge-detected step input advances a
// count held in JK stages; provides terminal-count and a registered wrap pulse.
module jk_mod_counter
  import jk_mod_counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic             clk2,
  input  logic             a_reset,
  input  logic             step,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic             r_wrap;
  logic             w_tick;
  ns_sel_e          w_sel;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap_next;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;

  // Two-flop synchronizer, edge history and wrap pulse register
  always_ff @(posedge clk2 or negedge a_reset) begin
    if (!a_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_sync1 <= step;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_wrap  <= w_wrap_next;
    end
  end

  assign w_tick = r_sync2 & ~r_prev;

  // Next-state source selection; load overrides and swallows a same-cycle tick
  always_comb begin
    w_sel = NS_HOLD;
    if (load) begin
      w_sel = NS_LOAD;
    end else if (w_tick && en) begin
      w_sel = (up == DIR_UP) ? NS_INC : NS_DEC;
    end else begin
      w_sel = NS_HOLD;
    end
  end

  // Next count value and wrap detection
  always_comb begin
    w_next      = w_q;
    w_wrap_next = 1'b0;
    case (w_sel)
      NS_LOAD: begin
        w_next = ({1'b0, load_val} < MOD_EXT) ? load_val : ZERO;
      end
      NS_INC: begin
        if (w_q == MAX_VAL) begin
          w_next      = ZERO;
          w_wrap_next = 1'b1;
        end else begin
          w_next = w_q + ONE;
        end
      end
      NS_DEC: begin
        if (w_q == ZERO) begin
          w_next      = MAX_VAL;
          w_wrap_next = 1'b1;
        end else begin
          w_next = w_q - ONE;
        end
      end
      default: begin
        w_next      = w_q;
        w_wrap_next = 1'b0;
      end
    endcase
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_stage
    assign {w_j[g], w_k[g]} = jk_excite(w_next[g], w_q[g]);

    jk_stage u_stage (
      .clk2    (clk2),
      .a_reset (a_reset),
      .J       (w_j[g]),
      .K       (w_k[g]),
      .Q       (w_q[g])
    );
  end

  assign count = w_q;
  assign wrap  = r_wrap;
  assign tc    = (up == DIR_UP) ? (w_q == MAX_VAL) : (w_q == ZERO);

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed scoreboard bench for jk_mod_counter (WIDTH=4, MODULUS=10).
module tb_jk_mod_counter;

  logic       clk2;
  logic       a_reset;
  logic       step;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       tc;
  logic       wrap;

  typedef struct {
    string      tag;
    logic [3:0] cnt;
    logic       wrp;
    logic       tcv;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_cnt    = 0;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk2     (clk2),
    .a_reset  (a_reset),
    .step     (step),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  task automatic cyc();
    @(posedge clk2);
    #1;
  endtask

  task automatic push(input string tag, input int cnt, input logic wrp);
    exp_t e;
    e.tag = tag;
    e.cnt = 4'(cnt);
    e.wrp = wrp;
    e.tcv = up ? (cnt == 9) : (cnt == 0);
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    n_checks++;
    assert (sb.size() > 0) else begin
      n_errors++;
      $error("FAIL scoreboard_empty observed=0 expected>0");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      assert (count === e.cnt) else begin
        n_errors++;
        $error("FAIL %s count observed=%0d expected=%0d", e.tag, count, e.cnt);
      end
      n_checks++;
      assert (wrap === e.wrp) else begin
        n_errors++;
        $error("FAIL %s wrap observed=%0b expected=%0b", e.tag, wrap, e.wrp);
      end
      n_checks++;
      assert (tc === e.tcv) else begin
        n_errors++;
        $error("FAIL %s tc observed=%0b expected=%0b", e.tag, tc, e.tcv);
      end
    end
  endtask

  // One step pulse; reference model advances the count and predicts wrap.
  task automatic do_step(input string tag);
    logic w;
    w = 1'b0;
    if (en) begin
      if (up) begin
        w     = (m_cnt == 9);
        m_cnt = w ? 0 : m_cnt + 1;
      end else begin
        w     = (m_cnt == 0);
        m_cnt = w ? 9 : m_cnt - 1;
      end
    end
    step = 1'b1;
    push(tag, m_cnt, w);
    cyc();
    step = 1'b0;
    cyc();
    cyc();
    check_pop();
  endtask

  task automatic do_load(input string tag, input int v);
    load     = 1'b1;
    load_val = 4'(v);
    m_cnt    = (v < 10) ? v : 0;
    push(tag, m_cnt, 1'b0);
    cyc();
    load = 1'b0;
    check_pop();
  endtask

  initial begin
    a_reset  = 1'b0;
    step     = 1'b0;
    en       = 1'b1;
    up       = 1'b1;
    load     = 1'b0;
    load_val = 4'd0;
    #3;
    push("reset_initial", 0, 1'b0);
    check_pop();
    cyc();
    a_reset = 1'b1;
    cyc();
    cyc();

    // asynchronous reset mid-cycle clears without a clock edge
    do_load("load5", 5);
    #2;
    a_reset = 1'b0;
    m_cnt   = 0;
    push("async_reset", 0, 1'b0);
    #1;
    check_pop();
    cyc();
    a_reset = 1'b1;
    cyc();
    do_step("step_after_reset");

    // up count through the wrap
    do_load("load0", 0);
    for (int i = 0; i < 10; i++) begin
      do_step($sformatf("up_%0d", i));
    end
    push("up_wrap_clear", m_cnt, 1'b0);
    cyc();
    check_pop();

    // down from zero wraps to 9
    up = 1'b0;
    #1;
    push("down_tc_at0", m_cnt, 1'b0);
    check_pop();
    do_step("down_wrap");
    push("down_wrap_clear", m_cnt, 1'b0);
    cyc();
    check_pop();
    do_step("down_plain");

    // loads, including an out-of-range value
    up = 1'b1;
    do_load("load7", 7);
    do_load("load12", 12);
    do_load("load3", 3);

    // load coincident with tick wins; tick is not replayed later
    step = 1'b1;
    cyc();
    step = 1'b0;
    cyc();
    do_load("load_vs_tick", 6);
    push("tick_discarded", m_cnt, 1'b0);
    cyc();
    cyc();
    check_pop();

    // long step high counts once
    step  = 1'b1;
    m_cnt = m_cnt + 1;
    push("long_step", m_cnt, 1'b0);
    repeat (20) cyc();
    step = 1'b0;
    repeat (3) cyc();
    check_pop();

    // disabled steps are dropped, no backlog
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_step($sformatf("en0_%0d", i));
    end
    en = 1'b1;
    push("no_backlog", m_cnt, 1'b0);
    repeat (4) cyc();
    check_pop();
    do_step("en1_resume");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
